// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, issue and writeback signals of the register file scoreboard.
// master = decode/issue + writeback side, slave = regfile_scoreboard.
// Signals: rs1/rs2 address/data/busy, issue_valid/issue_rd/issue_ready, we/wa/wd, busy_cnt.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int ADDR_W = $clog2(NREGS);
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic            we;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
    logic [ADDR_W:0] busy_cnt;
    modport master (
        output rs1_addr, rs2_addr, issue_valid, issue_rd, we, wa, wd,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, busy_cnt
    );
    modport slave (
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, we, wa, wd,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, issue_ready, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file (2 comb reads, 1 sync write) with per-register busy scoreboard.
// Ports: clk (rising edge), rst_n (async active-low), bus (regfile_scoreboard_if.slave).
// Optional macro REGFILE_BYPASS_EN: forwards the writeback data/busy-clear to reads and the issue check
// in the writeback cycle; undefined, the new value and cleared busy bit appear one cycle later.
module regfile_scoreboard #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);
    // x0 and indices beyond NREGS (RV32E upper half) read 0, ignore writes, never go busy
    function automatic logic f_valid(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < 6'(NREGS));
    endfunction

    logic [XLEN-1:0]   r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   w_cnt;
    logic [ADDR_W-1:0] w_rs1_i;
    logic [ADDR_W-1:0] w_rs2_i;
    logic [ADDR_W-1:0] w_rd_i;
    logic [ADDR_W-1:0] w_wa_i;
    logic              w_rs1_v;
    logic              w_rs2_v;
    logic              w_rd_v;
    logic              w_wb;
    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_fwdrd;
    logic              w_rd_busy;

    assign w_rs1_i = bus.rs1_addr[ADDR_W-1:0];
    assign w_rs2_i = bus.rs2_addr[ADDR_W-1:0];
    assign w_rd_i  = bus.issue_rd[ADDR_W-1:0];
    assign w_wa_i  = bus.wa[ADDR_W-1:0];
    assign w_rs1_v = f_valid(bus.rs1_addr);
    assign w_rs2_v = f_valid(bus.rs2_addr);
    assign w_rd_v  = f_valid(bus.issue_rd);
    assign w_wb    = bus.we && f_valid(bus.wa);

`ifdef REGFILE_BYPASS_EN
    assign w_fwd1  = w_wb && (bus.wa == bus.rs1_addr);
    assign w_fwd2  = w_wb && (bus.wa == bus.rs2_addr);
    assign w_fwdrd = w_wb && (bus.wa == bus.issue_rd);
`else
    assign w_fwd1  = 1'b0;
    assign w_fwd2  = 1'b0;
    assign w_fwdrd = 1'b0;
`endif

    assign bus.rs1_data    = !w_rs1_v ? '0 : w_fwd1 ? bus.wd : r_regs[w_rs1_i];
    assign bus.rs2_data    = !w_rs2_v ? '0 : w_fwd2 ? bus.wd : r_regs[w_rs2_i];
    assign bus.rs1_busy    = w_rs1_v && r_busy[w_rs1_i] && !w_fwd1;
    assign bus.rs2_busy    = w_rs2_v && r_busy[w_rs2_i] && !w_fwd2;
    assign w_rd_busy       = w_rd_v && r_busy[w_rd_i] && !w_fwdrd;
    assign bus.issue_ready = bus.issue_valid && !bus.rs1_busy && !bus.rs2_busy && !w_rd_busy;
    assign bus.busy_cnt    = r_cnt;

    // clear before set so a same-cycle issue to the written-back register keeps it busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb) w_busy_nxt[w_wa_i] = 1'b0;
        if (bus.issue_ready && w_rd_v) w_busy_nxt[w_rd_i] = 1'b1;
        w_cnt = '0;
        for (int i = 0; i < NREGS; i++) w_cnt = w_cnt + (ADDR_W+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt;
            if (w_wb) r_regs[w_wa_i] <= bus.wd;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed + randomized checks of regfile_scoreboard against an array-based model.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if #(.XLEN(32), .NREGS(32)) bus ();
    regfile_scoreboard_if #(.XLEN(32), .NREGS(16)) bus_e ();

    regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    regfile_scoreboard #(.XLEN(32), .NREGS(16)) dut_e (.clk(clk), .rst_n(rst_n), .bus(bus_e));

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_valid(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic w, input logic [4:0] wa, input logic [31:0] wd);
        if (!m_valid(a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (w && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    function automatic bit m_isbusy(input logic [4:0] a, input logic w, input logic [4:0] wa);
        if (!m_valid(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (w && wa == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic cycle(input logic [4:0] a1, input logic [4:0] a2, input logic iv, input logic [4:0] rd,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd);
        logic er;
        @(negedge clk);
        bus.rs1_addr = a1; bus.rs2_addr = a2; bus.issue_valid = iv; bus.issue_rd = rd;
        bus.we = w; bus.wa = wa; bus.wd = wd;
        #1;
        er = iv && !m_isbusy(a1, w, wa) && !m_isbusy(a2, w, wa) && !m_isbusy(rd, w, wa);
        chk("rs1_data", bus.rs1_data, m_read(a1, w, wa, wd));
        chk("rs2_data", bus.rs2_data, m_read(a2, w, wa, wd));
        chk("rs1_busy", 32'(bus.rs1_busy), 32'(m_isbusy(a1, w, wa)));
        chk("rs2_busy", 32'(bus.rs2_busy), 32'(m_isbusy(a2, w, wa)));
        chk("issue_ready", 32'(bus.issue_ready), 32'(er));
        @(posedge clk);
        if (w && m_valid(wa)) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (er && m_valid(rd)) m_busy[rd] = 1'b1;
        #1;
        chk("busy_cnt", 32'(bus.busy_cnt), 32'(m_count()));
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        m_clear();
        bus.rs1_addr = 0; bus.rs2_addr = 0; bus.issue_valid = 0; bus.issue_rd = 0;
        bus.we = 0; bus.wa = 0; bus.wd = 0;
        bus_e.rs1_addr = 0; bus_e.rs2_addr = 0; bus_e.issue_valid = 0; bus_e.issue_rd = 0;
        bus_e.we = 0; bus_e.wa = 0; bus_e.wd = 0;
        #2;
        chk("rst_cnt", 32'(bus.busy_cnt), 32'h0);
        chk("rst_ready", 32'(bus.issue_ready), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // x0: write ignored, issue to x0 never busy
        cycle(0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("x0_cnt", 32'(bus.busy_cnt), 32'h0);
        // scoreboard stall on x7
        cycle(0, 0, 1, 7, 0, 0, 0);
        cycle(1, 7, 1, 9, 0, 0, 0);
        cycle(1, 7, 1, 9, 1, 7, 32'hCAFE0001);
        cycle(1, 7, 1, 9, 0, 0, 0);
        // simultaneous set/clear of x3
        cycle(0, 0, 1, 3, 0, 0, 0);
        cycle(3, 0, 1, 3, 1, 3, 32'h33330003);
        cycle(3, 0, 0, 0, 0, 0, 0);
        // async reset with x5 busy and holding 0x1234
        cycle(0, 0, 0, 0, 1, 5, 32'h1234);
        cycle(5, 0, 1, 5, 0, 0, 0);
        @(negedge clk);
        bus.rs1_addr = 5; bus.issue_valid = 0; bus.we = 1; bus.wa = 6; bus.wd = 32'hFF;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data", bus.rs1_data, 32'h0);
        chk("arst_busy", 32'(bus.rs1_busy), 32'h0);
        chk("arst_cnt", 32'(bus.busy_cnt), 32'h0);
        m_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.we = 0;
        cycle(6, 5, 0, 0, 0, 0, 0);
        // fill all 31 registers, then retire in reverse order
        for (int i = 1; i < 32; i++) cycle(0, 0, 1, 5'(i), 0, 0, 0);
        chk("fill_cnt", 32'(bus.busy_cnt), 32'd31);
        for (int i = 31; i >= 1; i--) cycle(0, 0, 0, 0, 1, 5'(i), 32'hA5000000 + 32'(i) * 32'h00010101);
        chk("drain_cnt", 32'(bus.busy_cnt), 32'h0);
        for (int i = 1; i < 32; i++) cycle(5'(i), 5'(32 - i), 0, 0, 0, 0, 0);
        // randomized traffic
        for (int n = 0; n < 400; n++)
            cycle(pick(), pick(), 1'($urandom_range(0, 1)), pick(), 1'($urandom_range(0, 1)), pick(), $urandom);
        // RV32E instance: x20 is out of range, must not alias onto x4
        @(negedge clk);
        bus_e.we = 1; bus_e.wa = 4; bus_e.wd = 32'h44;
        @(negedge clk);
        bus_e.wa = 20; bus_e.wd = 32'h2020; bus_e.issue_valid = 1; bus_e.issue_rd = 20;
        bus_e.rs1_addr = 20; bus_e.rs2_addr = 4;
        #1;
        chk("e_x20_data", bus_e.rs1_data, 32'h0);
        chk("e_x20_busy", 32'(bus_e.rs1_busy), 32'h0);
        chk("e_ready", 32'(bus_e.issue_ready), 32'h1);
        @(posedge clk);
        #1;
        bus_e.we = 0; bus_e.issue_valid = 0;
        #1;
        chk("e_cnt", 32'(bus_e.busy_cnt), 32'h0);
        chk("e_x4", bus_e.rs2_data, 32'h44);
        chk("e_x20_after", bus_e.rs1_data, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
